// File: rtl/spike_aer_fifo.sv
// rtl/spike_aer_fifo.sv - timestep-tagged spike FIFO draining to an AER valid/ready link
module spike_aer_fifo #(
    parameter int ADDR_WIDTH = 14,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int PTR_WIDTH  = 6,
    parameter int OVF_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_spike_fifo_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_spike_fifo_wr_addr,
    input  logic                  i_processing_done,
    output logic                  o_aer_valid,
    input  logic                  i_aer_ready,
    output logic [ADDR_WIDTH-1:0] o_aer_addr,
    output logic [TS_WIDTH-1:0]   o_aer_timestep,
    output logic [PTR_WIDTH:0]    o_fifo_count,
    output logic                  o_fifo_full,
    output logic                  o_fifo_empty,
    output logic [TS_WIDTH-1:0]   o_timestep,
    output logic                  o_overflow,
    output logic [OVF_WIDTH-1:0]  o_overflow_cnt,
    input  logic                  i_clear_overflow
);

    localparam int ENTRY_W = ADDR_WIDTH + TS_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH:0] ONE_C   = (PTR_WIDTH + 1)'(1);

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wptr_q, rptr_q;
    logic [PTR_WIDTH:0]     count_q, count_d;
    logic [TS_WIDTH-1:0]    ts_q;
    logic [ENTRY_W-1:0]     head_q, head_d;
    logic                   ovf_q, ovf_d;
    logic [OVF_WIDTH-1:0]   ovf_cnt_q, ovf_cnt_d;

    logic                   full;
    logic                   push_ok;
    logic                   drop;
    logic                   pop;
    logic [ENTRY_W-1:0]     wr_entry;
    logic [ENTRY_W-1:0]     next_rd;

    // The count covers the head slot, so the head is a registered copy of mem[rptr].
    assign full     = (count_q == DEPTH_C);
    assign push_ok  = i_spike_fifo_wr_en && !full;
    assign drop     = i_spike_fifo_wr_en && full;
    assign pop      = (state_q == S_HOLD) && i_aer_ready;
    assign wr_entry = {i_spike_fifo_wr_addr, ts_q};
    assign next_rd  = mem[rptr_q + PTR_WIDTH'(1)];

    // Occupancy moves by at most one per cycle; push+pop cancel.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + ONE_C;
        end else if (!push_ok && pop) begin
            count_d = count_q - ONE_C;
        end
    end

    // Head slot FSM: refill from the buffer, or bypass a push when the buffer has nothing behind the head.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        case (state_q)
            S_EMPTY: begin
                if (push_ok) begin
                    state_d = S_HOLD;
                    head_d  = wr_entry;
                end
            end
            S_HOLD: begin
                if (pop) begin
                    if (count_q > ONE_C) begin
                        head_d = next_rd;
                    end else if (push_ok) begin
                        head_d = wr_entry;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Drop accounting; a drop in the same cycle as a clear survives as the first count.
    always_comb begin
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (i_clear_overflow) begin
            ovf_d     = drop;
            ovf_cnt_d = drop ? OVF_WIDTH'(1) : '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != '1) begin
                ovf_cnt_d = ovf_cnt_q + OVF_WIDTH'(1);
            end
        end
    end

    // Buffer storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q] <= wr_entry;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ts_q      <= '0;
            head_q    <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            head_q    <= head_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
            if (push_ok) begin
                wptr_q <= wptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_WIDTH'(1);
            end
            if (i_processing_done) begin
                ts_q <= ts_q + TS_WIDTH'(1);
            end
        end
    end

    assign o_aer_valid    = (state_q == S_HOLD);
    assign o_aer_addr     = head_q[ENTRY_W-1:TS_WIDTH];
    assign o_aer_timestep = head_q[TS_WIDTH-1:0];
    assign o_fifo_count   = count_q;
    assign o_fifo_full    = full;
    assign o_fifo_empty   = (count_q == '0);
    assign o_timestep     = ts_q;
    assign o_overflow     = ovf_q;
    assign o_overflow_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_spike_aer_fifo.sv
// tb/tb_spike_aer_fifo.sv - randomized queue-model bench for spike_aer_fifo
module tb_spike_aer_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [13:0] wr_addr = '0;
    logic        done = 1'b0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;
    logic        aer_valid;
    logic [13:0] aer_addr;
    logic [15:0] aer_ts;
    logic [6:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] timestep;
    logic        overflow;
    logic [15:0] overflow_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [13:0] a;
        logic [15:0] t;
    } ev_t;

    ev_t         q[$];
    logic [15:0] m_ts;
    bit          m_ovf;
    int          m_cnt;

    spike_aer_fifo dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_spike_fifo_wr_en   (wr_en),
        .i_spike_fifo_wr_addr (wr_addr),
        .i_processing_done    (done),
        .o_aer_valid          (aer_valid),
        .i_aer_ready          (ready),
        .o_aer_addr           (aer_addr),
        .o_aer_timestep       (aer_ts),
        .o_fifo_count         (fifo_count),
        .o_fifo_full          (fifo_full),
        .o_fifo_empty         (fifo_empty),
        .o_timestep           (timestep),
        .o_overflow           (overflow),
        .o_overflow_cnt       (overflow_cnt),
        .i_clear_overflow     (clr)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, advance the queue model at the edge, return 1 time unit after it.
    task automatic step(input bit w, input logic [13:0] a, input bit d, input bit r, input bit c);
        bit is_full;
        bit dropped;
        wr_en = w; wr_addr = a; done = d; ready = r; clr = c;
        @(posedge clk);
        is_full = (q.size() == 64);
        dropped = w && is_full;
        if (q.size() > 0 && r) void'(q.pop_front());
        if (w && !is_full) q.push_back('{a: a, t: m_ts});
        if (c) begin
            m_ovf = dropped;
            m_cnt = dropped ? 1 : 0;
        end else if (dropped) begin
            m_ovf = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        if (d) m_ts++;
        #1;
        wr_en = 1'b0; done = 1'b0; clr = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        wr_en = 1'b0; done = 1'b0; ready = 1'b0; clr = 1'b0;
        q.delete(); m_ts = '0; m_ovf = 1'b0; m_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (aer_valid !== 1'b0 || aer_addr !== 14'h0 || aer_ts !== 16'h0) begin
            failures++; $display("FAIL reset_out valid=%b addr=%h ts=%h required 0/0/0", aer_valid, aer_addr, aer_ts);
        end
        checks++;
        if (fifo_count !== 7'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            failures++; $display("FAIL reset_occ count=%0d empty=%b full=%b required 0/1/0", fifo_count, fifo_empty, fifo_full);
        end
        checks++;
        if (timestep !== 16'h0 || overflow !== 1'b0 || overflow_cnt !== 16'h0) begin
            failures++; $display("FAIL reset_ts ts=%h ovf=%b cnt=%0d required 0/0/0", timestep, overflow, overflow_cnt);
        end
    endtask

    task automatic test_single();
        apply_reset();
        step(1'b1, 14'h0005, 1'b0, 1'b1, 1'b0);
        checks++;
        if (aer_valid !== 1'b1 || aer_addr !== 14'h0005 || aer_ts !== 16'h0 || fifo_count !== 7'd1) begin
            failures++; $display("FAIL single_head valid=%b addr=%h ts=%h count=%0d required 1/0005/0000/1", aer_valid, aer_addr, aer_ts, fifo_count);
        end
        step(1'b0, 14'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (aer_valid !== 1'b0 || fifo_count !== 7'd0 || fifo_empty !== 1'b1) begin
            failures++; $display("FAIL single_pop valid=%b count=%0d empty=%b required 0/0/1", aer_valid, fifo_count, fifo_empty);
        end
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 14'(i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (fifo_full !== 1'b1 || fifo_count !== 7'd64 || aer_addr !== 14'd0) begin
            failures++; $display("FAIL fill full=%b count=%0d head=%0d required 1/64/0", fifo_full, fifo_count, aer_addr);
        end
        step(1'b1, 14'd100, 1'b0, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || overflow_cnt !== 16'd1 || fifo_count !== 7'd64) begin
            failures++; $display("FAIL drop ovf=%b cnt=%0d count=%0d required 1/1/64", overflow, overflow_cnt, fifo_count);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (aer_valid !== 1'b1 || aer_addr !== 14'(i) || fifo_count !== 7'(64 - i)) begin
                failures++; $display("FAIL drain_%0d valid=%b addr=%0d count=%0d required 1/%0d/%0d", i, aer_valid, aer_addr, fifo_count, i, 64 - i);
            end
            step(1'b0, 14'h0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (aer_valid !== 1'b0 || fifo_empty !== 1'b1) begin
            failures++; $display("FAIL drain_end valid=%b empty=%b required 0/1", aer_valid, fifo_empty);
        end
    endtask

    task automatic test_timestep();
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 14'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 14'd7, 1'b1, 1'b0, 1'b0);
        checks++;
        if (aer_valid !== 1'b1 || aer_addr !== 14'd7 || aer_ts !== 16'd3 || timestep !== 16'd4) begin
            failures++; $display("FAIL ts_tag valid=%b addr=%0d ts=%0d now=%0d required 1/7/3/4", aer_valid, aer_addr, aer_ts, timestep);
        end
    endtask

    task automatic test_stall();
        logic [13:0] a0;
        logic [15:0] t0;
        apply_reset();
        step(1'b1, 14'($urandom), 1'b1, 1'b0, 1'b0);
        a0 = q[0].a; t0 = q[0].t;
        for (int i = 0; i < 10; i++) begin
            step(i < 5, 14'($urandom), i[0], 1'b0, 1'b0);
            checks++;
            if (aer_valid !== 1'b1 || aer_addr !== a0 || aer_ts !== t0) begin
                failures++; $display("FAIL stall_%0d valid=%b addr=%h ts=%h required 1/%h/%h", i, aer_valid, aer_addr, aer_ts, a0, t0);
            end
        end
        checks++;
        if (fifo_count !== 7'd6) begin
            failures++; $display("FAIL stall_count count=%0d required 6", fifo_count);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (aer_valid !== 1'b1 || aer_addr !== q[0].a || aer_ts !== q[0].t) begin
                failures++; $display("FAIL stall_drain_%0d addr=%h ts=%h required %h/%h", i, aer_addr, aer_ts, q[0].a, q[0].t);
            end
            step(1'b0, 14'h0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (aer_valid !== 1'b0 || fifo_count !== 7'd0) begin
            failures++; $display("FAIL stall_end valid=%b count=%0d required 0/0", aer_valid, fifo_count);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 14'($urandom), 1'($urandom_range(0, 7) == 0), 1'b1, 1'b0);
            checks++;
            if (aer_valid !== 1'b1 || aer_addr !== q[0].a || aer_ts !== q[0].t || fifo_count !== 7'd1) begin
                failures++; $display("FAIL wrap_%0d valid=%b addr=%h ts=%h count=%0d required 1/%h/%h/1", i, aer_valid, aer_addr, aer_ts, fifo_count, q[0].a, q[0].t);
            end
        end
        step(1'b0, 14'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (aer_valid !== 1'b0 || fifo_count !== 7'd0) begin
            failures++; $display("FAIL wrap_end valid=%b count=%0d required 0/0", aer_valid, fifo_count);
        end
    endtask

    task automatic test_ts_wrap();
        apply_reset();
        for (int i = 0; i < 65535; i++) step(1'b0, 14'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (timestep !== 16'hFFFF) begin
            failures++; $display("FAIL ts_max ts=%h required ffff", timestep);
        end
        step(1'b1, 14'h1234, 1'b1, 1'b0, 1'b0);
        checks++;
        if (timestep !== 16'h0000 || aer_ts !== 16'hFFFF) begin
            failures++; $display("FAIL ts_wrap ts=%h tag=%h required 0000/ffff", timestep, aer_ts);
        end
    endtask

    task automatic test_clear_overflow();
        apply_reset();
        for (int i = 0; i < 66; i++) step(1'b1, 14'(i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || overflow_cnt !== 16'd2) begin
            failures++; $display("FAIL ovf_two ovf=%b cnt=%0d required 1/2", overflow, overflow_cnt);
        end
        step(1'b1, 14'd9, 1'b0, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b1 || overflow_cnt !== 16'd1 || fifo_count !== 7'd63) begin
            failures++; $display("FAIL clr_drop ovf=%b cnt=%0d count=%0d required 1/1/63", overflow, overflow_cnt, fifo_count);
        end
        step(1'b0, 14'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || overflow_cnt !== 16'd0) begin
            failures++; $display("FAIL clr ovf=%b cnt=%0d required 0/0", overflow, overflow_cnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 14'($urandom), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 30) == 0));
            checks++;
            if (aer_valid !== (q.size() > 0) || fifo_count !== 7'(q.size()) ||
                fifo_full !== (q.size() == 64) || fifo_empty !== (q.size() == 0) ||
                timestep !== m_ts || overflow !== m_ovf || overflow_cnt !== 16'(m_cnt) ||
                (q.size() > 0 && (aer_addr !== q[0].a || aer_ts !== q[0].t))) begin
                failures++;
                $display("FAIL rand_%0d valid=%b count=%0d ts=%h ovf=%b cnt=%0d addr=%h tag=%h required count=%0d ts=%h ovf=%b cnt=%0d head=%h/%h",
                         i, aer_valid, fifo_count, timestep, overflow, overflow_cnt, aer_addr, aer_ts,
                         q.size(), m_ts, m_ovf, m_cnt, (q.size() > 0) ? q[0].a : 14'h0, (q.size() > 0) ? q[0].t : 16'h0);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 14'(i + 3), 1'b1, 1'b0, 1'b0);
        checks++;
        if (aer_valid !== 1'b1 || fifo_count !== 7'd10) begin
            failures++; $display("FAIL pre_reset valid=%b count=%0d required 1/10", aer_valid, fifo_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (aer_valid !== 1'b0 || aer_addr !== 14'h0 || aer_ts !== 16'h0 || fifo_count !== 7'd0 ||
            fifo_empty !== 1'b1 || timestep !== 16'h0) begin
            failures++; $display("FAIL async_reset valid=%b addr=%h ts=%h count=%0d empty=%b now=%h required 0/0/0/0/1/0",
                                 aer_valid, aer_addr, aer_ts, fifo_count, fifo_empty, timestep);
        end
        q.delete(); m_ts = '0; m_ovf = 1'b0; m_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 14'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (aer_valid !== 1'b0 || fifo_count !== 7'd0) begin
            failures++; $display("FAIL post_reset valid=%b count=%0d required 0/0", aer_valid, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_timestep();
        test_stall();
        test_wrap();
        test_clear_overflow();
        test_random();
        test_reset_mid();
        test_ts_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_aer_fifo.md
Name: spike_aer_fifo

Overview:
- Downstream of the target-neuron layer: buffers the per-neuron spike writes (wr_en + neuron address) produced during each 10,000-neuron update loop.
- Tags each spike with the current timestep index.
- Drains spikes to an AER output link through a valid/ready handshake.
- Absorbs bursts while the consumer stalls; counts drops on overflow.

Parameters:
- ADDR_WIDTH, 14, neuron address width; matches the layer's spike address.
- TS_WIDTH, 16, timestep counter / tag width.
- FIFO_DEPTH, 64, entry count; must be a power of two.
- PTR_WIDTH, 6, log2(FIFO_DEPTH).
- OVF_WIDTH, 16, overflow drop counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_spike_fifo_wr_en  in  1  one-cycle push strobe from the neuron layer.
- i_spike_fifo_wr_addr  in  ADDR_WIDTH  address of the spiking neuron.
- i_processing_done  in  1  one-cycle pulse marking the end of the update loop; advances the timestep.
- o_aer_valid  out  1  output event available.
- i_aer_ready  in  1  consumer accepts the event.
- o_aer_addr  out  ADDR_WIDTH  event neuron address.
- o_aer_timestep  out  TS_WIDTH  event timestep tag.
- o_fifo_count  out  PTR_WIDTH+1  current occupancy (0..FIFO_DEPTH).
- o_fifo_full  out  1  count == FIFO_DEPTH.
- o_fifo_empty  out  1  count == 0.
- o_timestep  out  TS_WIDTH  current timestep counter.
- o_overflow  out  1  sticky drop flag.
- o_overflow_cnt  out  OVF_WIDTH  dropped-spike count, saturating.
- i_clear_overflow  in  1  clears o_overflow and o_overflow_cnt.

Behaviour:
- Reset (async, rst_n low):
  - Pointers, count, timestep, overflow flag and counter go to 0.
  - o_aer_valid = 0, o_aer_addr = 0, o_aer_timestep = 0.
  - o_fifo_empty = 1, o_fifo_full = 0.
  - Reset mid-burst discards all stored entries; no partial event is presented after release.
- Storage: circular buffer of {addr, timestep}, FIFO_DEPTH entries. Write and read pointers are PTR_WIDTH bits and wrap naturally from DEPTH-1 to 0. Count is a separate register.
- Push (wr_en=1):
  - If registered full == 0: store {wr_addr, o_timestep}, advance write pointer.
  - If full == 1: entry is dropped, even if a pop occurs in the same cycle. o_overflow is set; o_overflow_cnt increments and saturates at all-ones.
- Timestep:
  - o_timestep increments by 1 on i_processing_done and wraps modulo 2^TS_WIDTH.
  - A push coinciding with i_processing_done is tagged with the pre-increment value.
- Output stage: registered head slot (first-word-fall-through).
  - Two states. EMPTY: o_aer_valid = 0. HOLD: o_aer_valid = 1.
  - EMPTY -> HOLD one cycle after an entry becomes available, either from the buffer or from a push into an empty FIFO. Minimum latency from push to o_aer_valid is 1 cycle.
  - Pop occurs when o_aer_valid && i_aer_ready.
  - On pop: reload the head from the buffer if another entry exists (stay in HOLD, back-to-back, 1 event/cycle); otherwise go to EMPTY.
  - While valid && !ready, o_aer_addr and o_aer_timestep hold stable.
  - o_aer_valid never deasserts without a pop.
- Occupancy: o_fifo_count includes the head slot.
  - Push and pop in the same cycle leave count unchanged (non-full case).
  - Count only changes by -1, 0 or +1 per cycle.
- Overflow clear:
  - i_clear_overflow zeroes the flag and counter.
  - If a drop happens in the same cycle as the clear, the result is flag = 1, cnt = 1.
- Empty pop: i_aer_ready with o_aer_valid = 0 has no effect.

Test Plan:
1. Reset, push addr 0x0005 at timestep 0 with ready = 1 -> o_aer_valid rises 1 cycle later with addr 0x0005, ts 0; popped that cycle; count returns to 0.
2. Ready = 0, push 64 addrs 0..63 -> full = 1, count = 64. Push addr 100 -> dropped; overflow = 1, cnt = 1. Then ready = 1 -> exactly 64 events out, addrs 0..63 in order, 1/cycle.
3. Pulse i_processing_done 3 times, then push addr 7 together with a 4th i_processing_done pulse -> event shows ts 3; o_timestep = 4.
4. Valid held with ready = 0 for 10 cycles while 5 more pushes arrive -> addr/ts stable throughout; count = 6; ready = 1 drains in order.
5. Write and read pointers wrap: run 200 push/pop pairs with ready = 1 -> no loss, order preserved, count ≤ 1. Separately, force o_timestep from 0xFFFF via one i_processing_done pulse -> wraps to 0x0000.
6. Deassert rst_n with 10 entries stored and valid high -> all outputs zero and empty = 1 immediately. i_clear_overflow coincident with a drop -> cnt = 1.
